// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Byte-wide UART transmitter. A request accepted in IDLE is sent as one
//   frame: start bit, 8 data bits LSB first, an optional parity bit and 1 or 2
//   stop bits. Bit timing comes from an internal baud counter dividing clk.
//
// Ports
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous active-low reset
//   tx_start  in   1  send request, sampled only while idle
//   tx_data   in   8  byte to send, captured when tx_start is accepted
//   tx_busy   out  1  high while a frame is in progress
//   tx_done   out  1  one-cycle pulse during the last cycle of the final stop bit
//   tx        out  1  serial line, idles high
module uart_tx_serializer #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CNT_W-1:0] TICK_VAL     = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_TICK_VAL = CNT_W'(BAUD_DIV - 2);
  localparam logic             STOP_LAST    = 1'(STOP_BITS - 1);
  localparam logic             ODD_SEL      = 1'(PARITY_ODD);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic             r_stop_cnt;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;

  logic w_tick;
  logic w_last_stop;
  logic w_done_next;

  assign w_tick      = (r_baud_cnt == TICK_VAL);
  assign w_last_stop = (r_stop_cnt == STOP_LAST);
  // tx_done must be high during the tick cycle itself, so it is registered one
  // cycle early, when the counter is one short of the final bit-end tick.
  assign w_done_next = (r_state == S_STOP) && w_last_stop && (r_baud_cnt == PRE_TICK_VAL);

  // Every output is driven from its own flop, and each transition loads the
  // line value of the state being entered so tx changes exactly on bit edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      // NOTE: the shift register is small and the reset state is part of the
      // block's contract, so it is cleared along with the control state.
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // below sees the values from the start of the cycle.
      r_done <= w_done_next;

      if (r_state != S_IDLE) begin
        r_baud_cnt <= w_tick ? '0 : r_baud_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            r_state    <= S_START;
            r_shift    <= tx_data;
            r_parity   <= (^tx_data) ^ ODD_SEL;
            r_baud_cnt <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        S_START: begin
          if (w_tick) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
          end
        end

        S_DATA: begin
          if (w_tick) begin
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state    <= S_STOP;
                r_stop_cnt <= 1'b0;
                r_tx       <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              // Next data bit is shift[1]; the shifted copy lands this edge.
              r_tx      <= r_shift[1];
            end
          end
        end

        S_PARITY: begin
          if (w_tick) begin
            r_state    <= S_STOP;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
          end
        end

        S_STOP: begin
          if (w_tick) begin
            if (w_last_stop) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_tx    <= 1'b1;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
//   Directed bench for uart_tx_serializer at BAUD_DIV=10 in three framings:
//   dut_a 8N1, dut_b 8E2, dut_c 8O1. Each cycle of a frame compares the
//   triple {tx, tx_busy, tx_done} against a hand-built bit sequence.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       start_a, start_b, start_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       tx_a, tx_b, tx_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .tx_start(start_a), .tx_data(tx_data),
    .tx_busy(busy_a), .tx_done(done_a), .tx(tx_a)
  );

  uart_tx_serializer #(
    .CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .reset(reset), .tx_start(start_b), .tx_data(tx_data),
    .tx_busy(busy_b), .tx_done(done_b), .tx(tx_b)
  );

  uart_tx_serializer #(
    .CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) dut_c (
    .clk(clk), .reset(reset), .tx_start(start_c), .tx_data(tx_data),
    .tx_busy(busy_c), .tx_done(done_c), .tx(tx_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {tx, tx_busy, tx_done} of the selected instance
  function automatic logic [2:0] line_of(input int sel);
    case (sel)
      0:       return {tx_a, busy_a, done_a};
      1:       return {tx_b, busy_b, done_b};
      default: return {tx_c, busy_c, done_c};
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Entered and left at a negedge. Pulses tx_start for one cycle, then checks
  // every cycle of the frame and the first idle cycle after it. When
  // repulse_at > 0, a 0x3C request is pulsed at that frame cycle.
  task automatic run_frame(input int sel, input logic [7:0] data, input logic exp_par,
                           input int pe, input int sb, input int repulse_at,
                           input string tag);
    logic [11:0] bits;
    int          len;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (pe != 0) bits[9] = exp_par;
    len = (9 + pe + sb) * 10;

    tx_data = data;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int n = 1; n <= len; n++) begin
      check($sformatf("%s c%0d", tag, n), {29'd0, line_of(sel)},
            {29'd0, bits[(n-1)/10], 1'b1, (n == len)});
      if (n == repulse_at) begin
        tx_data = 8'h3C;
        set_start(sel, 1'b1);
      end else if (n == repulse_at + 1) begin
        set_start(sel, 1'b0);
      end
      @(negedge clk);
    end
    check($sformatf("%s idle", tag), {29'd0, line_of(sel)}, 32'h4);
  endtask

  initial begin
    reset   = 1'b1;
    tx_data = 8'h00;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    #1 reset = 1'b0;
    #10;
    check("reset a", {29'd0, line_of(0)}, 32'h4);
    check("reset b", {29'd0, line_of(1)}, 32'h4);
    check("reset c", {29'd0, line_of(2)}, 32'h4);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1, 0xA5: 100-cycle frame
    run_frame(0, 8'hA5, 1'b0, 0, 1, -1, "a5_8n1");
    repeat (4) @(negedge clk);

    // 8E2, 0x07: three ones -> even parity bit 1, 120-cycle frame
    run_frame(1, 8'h07, 1'b1, 1, 2, -1, "07_8e2");
    repeat (4) @(negedge clk);

    // 8O1: 0x00 -> parity 1, 0xFF -> parity 1
    run_frame(2, 8'h00, 1'b1, 1, 1, -1, "00_8o1");
    repeat (4) @(negedge clk);
    run_frame(2, 8'hFF, 1'b1, 1, 1, -1, "ff_8o1");
    repeat (4) @(negedge clk);

    // 0x55 with a 0x3C request pulsed mid-frame: must be ignored
    run_frame(0, 8'h55, 1'b0, 0, 1, 35, "55_repulse");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check($sformatf("no_second_frame %0d", i), {29'd0, line_of(0)}, 32'h4);
    end

    // Back-to-back: second request lands in the first idle cycle after tx_done
    run_frame(0, 8'hC3, 1'b0, 0, 1, -1, "b2b_first");
    run_frame(0, 8'h81, 1'b0, 0, 1, -1, "b2b_second");
    repeat (4) @(negedge clk);

    // Reset asserted mid-DATA, away from any clock edge
    tx_data = 8'h5A;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (34) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async", {29'd0, line_of(0)}, 32'h4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold %0d", i), {29'd0, line_of(0)}, 32'h4);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_quiet %0d", i), {29'd0, line_of(0)}, 32'h4);
    end
    run_frame(0, 8'h12, 1'b0, 0, 1, -1, "12_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-wide UART transmitter directly downstream of the output interface.
- Consumes tx_start/tx_data, returns tx_busy, and drives the board's serial TX pin with a configurable frame: 8 data bits, optional parity, 1 or 2 stop bits.
- Bit timing is derived from the system clock by an internal baud counter.

Parameters:
- CLK_FREQUENCY, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits/s. BAUD_DIV = CLK_FREQUENCY / BAUD_RATE (integer, truncated); legal BAUD_DIV is at least 4.
- PARITY_EN, 0: 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0: when PARITY_EN=1, 0 selects even parity and 1 selects odd parity.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_start  input  1  request to send tx_data; sampled only in IDLE.
- tx_data  input  8  byte to transmit; captured in the cycle tx_start is accepted.
- tx_busy  output  1  high while a frame is in progress (registered).
- tx_done  output  1  one-cycle pulse when the final stop bit completes.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx=1, tx_busy=0, tx_done=0, baud counter=0, bit index=0, shift register=0. Deassertion is synchronous to clk by design use; a frame in flight is abandoned and tx returns high immediately.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_busy=0.
  - If tx_start=1: latch tx_data into the shift register, compute the parity bit (XOR of the 8 bits, inverted if PARITY_ODD), clear the baud counter, and enter START.
  - tx=0 and tx_busy=1 from the next cycle onward (one-cycle latency from accept to the falling start edge).
- Baud counter: counts 0..BAUD_DIV-1 in every non-IDLE state. The cycle it equals BAUD_DIV-1 is the bit-end tick; the counter wraps to 0 on that cycle. Each bit is held for exactly BAUD_DIV cycles.
- START: tx=0. On tick: go to DATA with bit index=0.
- DATA: tx = shift_reg[0], so bits go LSB first. On tick: shift right and increment bit index.
  - After bit index 7 ticks, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = parity bit. On tick: go to STOP.
- STOP: tx=1. A stop-bit counter runs 0..STOP_BITS-1.
  - On tick with the last stop bit: go to IDLE, tx_done=1 for that single cycle, and tx_busy falls the following cycle (the first IDLE cycle).
- Frame length: exactly (1 + 8 + PARITY_EN + STOP_BITS) * BAUD_DIV cycles from the first tx=0 cycle to the first IDLE cycle.
- tx_start while tx_busy=1 is ignored, with no queuing. tx_data changes during a frame have no effect.
- Back-to-back transfers: tx_start asserted in the first IDLE cycle after tx_done is accepted. The gap is therefore zero extra idle bit times beyond the stop bit(s).
- tx_start held high continuously: a new frame starts each time IDLE is reached. Upstream is responsible for pulsing.
- tx is a registered output (glitch-free). No combinational path from any input to any output.

Test Plan:
- Parameters CLK_FREQUENCY=1000, BAUD_RATE=100 (BAUD_DIV=10), 8N1. Pulse tx_start with tx_data=0xA5. Required:
  - tx low from accept+1 for 10 cycles.
  - Data bits 1,0,1,0,0,1,0,1, each 10 cycles.
  - tx high for the stop bit.
  - tx_done pulses once at cycle 100 after start; tx_busy=1 for exactly 100 cycles.
- Same clocking with PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, tx_data=0x07:
  - Parity bit = 1 (three ones, even parity).
  - Two 10-cycle stop bits.
  - Frame length 120 cycles.
- PARITY_ODD=1, tx_data=0x00 -> parity bit = 1. tx_data=0xFF -> parity bit = 1.
- tx_start re-pulsed mid-frame with tx_data=0x3C while sending 0x55 -> line carries only 0x55; no second frame; a single tx_done.
- tx_start asserted in the first IDLE cycle after tx_done with tx_data=0x81 -> second start bit begins the next cycle; no extra idle time.
- reset driven low mid-DATA, then released:
  - tx=1, tx_busy=0, tx_done=0 asynchronously, with no further line activity.
  - A new 0x12 request afterwards transmits correctly.
